clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 137 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a start/stop/oneshot sequencer and a
// ready/valid divisor reload that only ever takes effect on a period boundary.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | counter parked at 0, y low, waiting for start without stop
// RUN    | counting; y toggles and tick pulses on every terminal count
// STOP   | counting out the current period, then y forced low, to IDLE
module clk_div_ctrl #(
  parameter int unsigned W         = 16,
  parameter int unsigned DEFAULT_N = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic [W-1:0] div_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         tick,
  output logic         y,
  output logic         busy,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] DIV_RST = W'(DEFAULT_N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_val_q, pend_val_d;
  logic         pend_q, pend_d;
  logic         os_q, os_d;
  logic         y_q, y_d;
  logic         tick_q, tick_d;

  logic         xfer;
  logic         term;

  assign xfer = load_valid & ~pend_q;
  assign term = (count_q == div_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    os_d       = os_q;
    y_d        = y_q;
    tick_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        y_d     = 1'b0;
        // A reload left over from a run that just ended lands here.
        if (pend_q) begin
          div_d  = pend_val_q;
          pend_d = 1'b0;
        end
        if (xfer) div_d = div_in;
        if (start && !stop) begin
          state_d = S_RUN;
          os_d    = oneshot;
        end
      end

      S_RUN, S_STOP: begin
        if (term) begin
          count_d = '0;
          tick_d  = 1'b1;
          if (pend_q) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
          end
          if (state_q == S_STOP || os_q) begin
            y_d     = 1'b0;
            state_d = S_IDLE;
          end else begin
            y_d = ~y_q;
          end
        end else begin
          count_d = count_q + 1'b1;
          if (state_q == S_RUN && stop) state_d = S_STOP;
        end
        // Captured after the terminal update so it waits for the next boundary.
        if (xfer) begin
          pend_d     = 1'b1;
          pend_val_d = div_in;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
        y_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      div_q      <= DIV_RST;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      os_q       <= 1'b0;
      y_q        <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      os_q       <= os_d;
      y_q        <= y_d;
      tick_q     <= tick_d;
    end
  end

  assign load_ready = ~pend_q;
  assign tick       = tick_q;
  assign y          = y_q;
  assign busy       = (state_q != S_IDLE);
  assign count      = count_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a vector table for the basic run plus
// hand-written sequences for reload, stop, oneshot, N=0 and reset corners.
module tb_clk_div_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         stop;
  logic         oneshot;
  logic [W-1:0] div_in;
  logic         load_valid;
  logic         load_ready;
  logic         tick;
  logic         y;
  logic         busy;
  logic [W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_ctrl #(.W(W), .DEFAULT_N(255)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
    .div_in     (div_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .tick       (tick),
    .y          (y),
    .busy       (busy),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rn;
    logic         st;
    logic         sp;
    logic         os;
    logic         lv;
    logic [W-1:0] din;
    logic         e_tick;
    logic         e_y;
    logic         e_busy;
    logic [W-1:0] e_cnt;
    logic         e_rdy;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic rn, logic st, logic sp, logic os, logic lv,
                              logic [W-1:0] din, logic et, logic ey, logic eb,
                              logic [W-1:0] ec, logic er);
    vec_t v;
    v.rn = rn; v.st = st; v.sp = sp; v.os = os; v.lv = lv; v.din = din;
    v.e_tick = et; v.e_y = ey; v.e_busy = eb; v.e_cnt = ec; v.e_rdy = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; stop = 1'b0; oneshot = 1'b0; load_valid = 1'b0; div_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic load_idle(input logic [W-1:0] v);
    load_valid = 1'b1; div_in = v;
    step();
    load_valid = 1'b0;
  endtask

  task automatic start_run(input logic os);
    start = 1'b1; oneshot = os;
    step();
    start = 1'b0; oneshot = 1'b0;
  endtask

  // Steps until tick is seen; n is the number of steps taken, or -1 on timeout.
  task automatic wait_tick(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      if (!seen) begin
        step();
        if (tick === 1'b1) begin
          seen = 1'b1;
          n = i;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int ticks;
    int busy_seen;

    reset_n = 1'b1;
    clear_inputs();

    // Load 3 in IDLE, start: tick every 4, y period 8; then reset and a
    // simultaneous load+start must use the new divisor from the first period.
    vecs[0]  = mk(0,0,0,0,0, 0,  0,0,0,0,1);
    vecs[1]  = mk(1,0,0,0,1, 3,  0,0,0,0,1);
    vecs[2]  = mk(1,1,0,0,0, 0,  0,0,1,0,1);
    vecs[3]  = mk(1,0,0,0,0, 0,  0,0,1,1,1);
    vecs[4]  = mk(1,0,0,0,0, 0,  0,0,1,2,1);
    vecs[5]  = mk(1,0,0,0,0, 0,  0,0,1,3,1);
    vecs[6]  = mk(1,0,0,0,0, 0,  1,1,1,0,1);
    vecs[7]  = mk(1,0,0,0,0, 0,  0,1,1,1,1);
    vecs[8]  = mk(1,0,0,0,0, 0,  0,1,1,2,1);
    vecs[9]  = mk(1,0,0,0,0, 0,  0,1,1,3,1);
    vecs[10] = mk(1,0,0,0,0, 0,  1,0,1,0,1);
    vecs[11] = mk(0,0,0,0,0, 0,  0,0,0,0,1);
    vecs[12] = mk(1,1,0,0,1, 1,  0,0,1,0,1);
    vecs[13] = mk(1,0,0,0,0, 0,  0,0,1,1,1);
    vecs[14] = mk(1,0,0,0,0, 0,  1,1,1,0,1);

    for (int i = 0; i < 15; i++) begin
      reset_n = vecs[i].rn; start = vecs[i].st; stop = vecs[i].sp;
      oneshot = vecs[i].os; load_valid = vecs[i].lv; div_in = vecs[i].din;
      step();
      chk($sformatf("vec%0d tick", i),  32'(tick),       32'(vecs[i].e_tick));
      chk($sformatf("vec%0d y", i),     32'(y),          32'(vecs[i].e_y));
      chk($sformatf("vec%0d busy", i),  32'(busy),       32'(vecs[i].e_busy));
      chk($sformatf("vec%0d count", i), 32'(count),      32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d ready", i), 32'(load_ready), 32'(vecs[i].e_rdy));
    end
    clear_inputs();

    // Reload 9 mid-period with N=3: current period stays 4, then 10.
    do_reset();
    load_idle(3);
    start_run(1'b0);
    step();
    chk("reload count1", 32'(count), 1);
    load_valid = 1'b1; div_in = 9;
    step();
    load_valid = 1'b0;
    chk("reload ready_pending", 32'(load_ready), 0);
    step();
    chk("reload ready_count3", 32'(load_ready), 0);
    chk("reload no_early_tick", 32'(tick), 0);
    step();
    chk("reload first_tick_at4", 32'(tick), 1);
    chk("reload ready_back", 32'(load_ready), 1);
    wait_tick(20, n);
    chk("reload period2", 32'(n), 10);
    wait_tick(20, n);
    chk("reload period3", 32'(n), 10);

    // Load on a terminal cycle lands one terminal later; stop on terminal is lost.
    do_reset();
    load_idle(3);
    start_run(1'b0);
    step(); step(); step();
    chk("termload count3", 32'(count), 3);
    load_valid = 1'b1; div_in = 1; stop = 1'b1;
    step();
    load_valid = 1'b0; stop = 1'b0;
    chk("termload tick", 32'(tick), 1);
    chk("termload ready", 32'(load_ready), 0);
    chk("termstop still_run", 32'(busy), 1);
    wait_tick(20, n);
    chk("termload old_period", 32'(n), 4);
    chk("termstop busy_after", 32'(busy), 1);
    wait_tick(20, n);
    chk("termload new_period", 32'(n), 2);

    // Graceful stop at count=2 with N=5.
    do_reset();
    load_idle(5);
    start_run(1'b0);
    step(); step();
    chk("stop count2", 32'(count), 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop busy1", 32'(busy), 1);
    chk("stop count3", 32'(count), 3);
    step();
    chk("stop busy2", 32'(busy), 1);
    step();
    chk("stop busy3", 32'(busy), 1);
    chk("stop no_tick3", 32'(tick), 0);
    step();
    chk("stop tick4", 32'(tick), 1);
    chk("stop idle", 32'(busy), 0);
    chk("stop y0", 32'(y), 0);
    chk("stop count0", 32'(count), 0);
    step();
    chk("stop tick_gone", 32'(tick), 0);

    // Oneshot with N=2: one tick 3 cycles after start, then quiet.
    do_reset();
    load_idle(2);
    start_run(1'b1);
    wait_tick(10, n);
    chk("oneshot delay", 32'(n), 3);
    chk("oneshot busy0", 32'(busy), 0);
    chk("oneshot y0", 32'(y), 0);
    ticks = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick === 1'b1) ticks++;
      if (busy === 1'b1) busy_seen++;
    end
    chk("oneshot extra_ticks", 32'(ticks), 0);
    chk("oneshot busy_after", 32'(busy_seen), 0);

    // N=0: tick every cycle, y toggles every cycle.
    do_reset();
    load_idle(0);
    start_run(1'b0);
    chk("n0 busy", 32'(busy), 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("n0 tick%0d", i), 32'(tick), 1);
      chk($sformatf("n0 y%0d", i), 32'(y), 32'(i % 2));
    end

    // start and stop together in IDLE keeps the block idle.
    do_reset();
    start = 1'b1; stop = 1'b1;
    step();
    chk("ststop busy1", 32'(busy), 0);
    step();
    chk("ststop busy2", 32'(busy), 0);
    clear_inputs();

    // Reset at count=7 of N=10 with a reload of 20 pending.
    do_reset();
    load_idle(10);
    start_run(1'b0);
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) begin
        load_valid = 1'b1; div_in = 20;
      end
      step();
      load_valid = 1'b0;
    end
    chk("rst count7", 32'(count), 7);
    chk("rst pending", 32'(load_ready), 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst tick", 32'(tick), 0);
    chk("rst y", 32'(y), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst count", 32'(count), 0);
    chk("rst ready", 32'(load_ready), 1);
    start_run(1'b0);
    wait_tick(300, n);
    chk("rst default_period", 32'(n), 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
